rca_byte_sequencer: RTL and testbench
=====================================

// Module: rca_byte_sequencer
// PURPOSE
//  Multi-cycle wide adder controller that drives a single 8-bit ripple-carry adder stage.
//  - Accepts two NBYTES-wide operands plus carry-in over a valid/ready handshake.
//  - Feeds one byte pair per cycle to the external rca_8bit, LSB byte first.
//  - Carry is held in a register between cycles; returned sum bytes are collected.
//  - Result is presented with cout and a signed-overflow flag.
// PARAMETERS
//  NBYTES  4  operand width in bytes (>=1); operand/sum width W = 8*NBYTES
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    synchronous reset, active-low
//  in_valid   in   1    operands a/b/cin valid
//  in_ready   out  1    block can accept operands
//  a          in   W    operand A
//  b          in   W    operand B
//  cin        in   1    carry-in to byte 0
//  add_x      out  8    byte of A to adder x
//  add_y      out  8    byte of B to adder y
//  add_ci     out  1    carry to adder ci
//  add_s      in   8    adder sum s (combinational return)
//  add_co     in   1    adder carry-out co
//  out_valid  out  1    result valid
//  out_ready  in   1    consumer accepts result
//  sum        out  W    A+B+cin, modulo 2^W
//  cout       out  1    carry out of bit W-1
//  ovf        out  1    two's-complement overflow
//  busy       out  1    high in RUN
// BEHAVIOUR
//  - Reset: when rst_n=0 at a clk edge, the FSM goes to IDLE.
//    - All registers are cleared: operands, idx, carry, sum, cout, ovf.
//    - Outputs after reset: in_ready=1, out_valid=0, busy=0.
//  - FSM states:
//    - IDLE: in_ready=1. On in_valid&in_ready, register a, b, cin into carry_reg, set idx=0, go to RUN.
//    - RUN: busy=1, in_ready=0. in_valid is ignored.
//      - Each cycle: sum byte[idx] <= add_s, carry_reg <= add_co.
//      - If idx==NBYTES-1: set cout <= add_co, set ovf, go to DONE. Otherwise idx++.
//    - DONE: out_valid=1. sum/cout/ovf are stable while waiting.
//      - On out_ready go to IDLE. There is no back-to-back accept in DONE.
//  - Adder drive (combinational from registers):
//    - add_x = a_reg[8*idx+:8], add_y = b_reg[8*idx+:8], add_ci = carry_reg.
//    - In IDLE/DONE, add_x/add_y/add_ci are 0.
//  - Overflow, on the last byte:
//    - c7 = a_reg[W-1]^b_reg[W-1]^add_s[7] is the carry into the MSB.
//    - ovf <= c7 ^ add_co.
//  - Latency: accept edge at T. RUN occupies edges T+1..T+NBYTES. out_valid is first high after edge T+NBYTES.
//    - Throughput: one operation per NBYTES+2 cycles, given immediate out_ready.
//  - idx width is clog2(NBYTES), minimum 1. idx never exceeds NBYTES-1.
//  - Reset mid-RUN or mid-DONE aborts the operation. No result is emitted.
//  - Outputs sum/cout/ovf hold their last value in IDLE.
// TESTING (NBYTES=4; bench instantiates rca_8bit on the add_* ports)
//  - Reset: rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
//  - a=0x000000FF, b=0x00000001, cin=0 -> sum=0x00000100, cout=0, ovf=0.
//    - out_valid first high 4 cycles after the accept edge.
//  - a=0xFFFFFFFF, b=0, cin=1 -> sum=0x00000000, cout=1, ovf=0 (carry ripples all 4 bytes).
//  - a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
//  - Back-pressure: hold out_ready=0 for 5 cycles in DONE.
//    - Result stays stable; in_ready=0; a new in_valid is not accepted.
//    - Then out_ready=1 -> IDLE next cycle.
//  - Mid-RUN abort: pulse in_valid with new operands during RUN -> ignored.
//    - Then drop rst_n for 1 cycle at idx=2 -> IDLE, out_valid never asserted for that operation.

Source files
------------

// File: rtl/rca_byte_sequencer.sv
// rca_byte_sequencer
//
// Multi-cycle wide adder controller. It accepts two NBYTES-wide operands and a
// carry-in, then drives an external 8-bit ripple-carry adder one byte pair per
// cycle, LSB byte first. The carry is kept in a register between cycles and the
// returned sum bytes are collected. The result is presented together with the
// carry out and a two's-complement overflow flag.
//
// Parameters
//   NBYTES     operand width in bytes (>= 1); W = 8*NBYTES
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   in_valid   operands a/b/cin valid
//   in_ready   block can accept operands (IDLE)
//   a, b       W-bit operands
//   cin        carry into byte 0
//   add_x      byte of A to the adder
//   add_y      byte of B to the adder
//   add_ci     carry to the adder
//   add_s      adder sum (combinational return)
//   add_co     adder carry out
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   sum        A+B+cin modulo 2^W
//   cout       carry out of bit W-1
//   ovf        two's-complement overflow
//   busy       high while bytes are being added (RUN)

module rca_byte_sequencer #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] a,
  input  logic [8*NBYTES-1:0] b,
  input  logic                cin,
  output logic [7:0]          add_x,
  output logic [7:0]          add_y,
  output logic                add_ci,
  input  logic [7:0]          add_s,
  input  logic                add_co,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] sum,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);

  localparam int unsigned W    = 8 * NBYTES;
  // A single-byte operand still needs a 1-bit index register.
  localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IdxW-1:0] idx_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  // Carry into the MSB of the last byte, recovered from the MSB sum bit.
  logic            msb_carry_in;

  assign msb_carry_in = a_q[W-1] ^ b_q[W-1] ^ add_s[7];

  // Single state machine; handshake and status outputs are registered so they
  // change together with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry_q    <= cin;
            idx_q      <= '0;
            state_q    <= StRun;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end

        StRun: begin
          sum_q[8*idx_q +: 8] <= add_s;
          carry_q             <= add_co;
          if (idx_q == LastIdx) begin
            cout_q      <= add_co;
            ovf_q       <= msb_carry_in ^ add_co;
            state_q     <= StDone;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        StDone: begin
          // No new operands are taken here; the next accept happens in IDLE.
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Adder drive: the current byte pair while running, zero otherwise.
  always_comb begin
    add_x  = 8'h00;
    add_y  = 8'h00;
    add_ci = 1'b0;
    if (state_q == StRun) begin
      add_x  = a_q[8*idx_q +: 8];
      add_y  = b_q[8*idx_q +: 8];
      add_ci = carry_q;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_byte_sequencer.sv
// Testbench for rca_byte_sequencer (NBYTES = 4). A behavioural 8-bit adder sits
// on the add_* ports. Expected results are queued on accept and checked by an
// independent monitor whenever a result is handed over.

module tb_rca_byte_sequencer;

  localparam int unsigned NBYTES = 4;
  localparam int unsigned W      = 8 * NBYTES;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [7:0]   add_x;
  logic [7:0]   add_y;
  logic         add_ci;
  logic [7:0]   add_s;
  logic         add_co;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } result_t;

  result_t exp_q[$];
  int      n_checks = 0;
  int      n_fail   = 0;

  rca_byte_sequencer #(
    .NBYTES (NBYTES)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .add_x     (add_x),
    .add_y     (add_y),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  // Behavioural rca_8bit stage.
  assign {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y} + {8'd0, add_ci};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a result is handed over when out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got sum 0x%0h, expected no result", sum);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        check("sb_sum", sum, e.sum);
        check("sb_cout", W'(cout), W'(e.cout));
        check("sb_ovf", W'(ovf), W'(e.ovf));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation with `hold` cycles of back-pressure in DONE.
  task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin,
                       input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf,
                       input int hold);
    result_t e;
    int      lat;
    a        = op_a;
    b        = op_b;
    cin      = op_cin;
    in_valid = 1'b1;
    check("in_ready_idle", W'(in_ready), W'(1'b1));
    step();  // accept edge
    e.sum  = e_sum;
    e.cout = e_cout;
    e.ovf  = e_ovf;
    exp_q.push_back(e);
    in_valid = 1'b0;
    check("busy_run", W'(busy), W'(1'b1));
    check("in_ready_run", W'(in_ready), W'(1'b0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", W'(lat), W'(NBYTES));
    if (!out_valid) return;
    // Back-pressure: result must hold and new operands must be refused.
    for (int i = 0; i < hold; i++) begin
      a        = 32'hDEADBEEF;
      b        = 32'h0BADF00D;
      in_valid = 1'b1;
      check("bp_out_valid", W'(out_valid), W'(1'b1));
      check("bp_in_ready", W'(in_ready), W'(1'b0));
      check("bp_sum_stable", sum, e_sum);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_after_done_valid", W'(out_valid), W'(1'b0));
    check("idle_after_done_ready", W'(in_ready), W'(1'b1));
    check("hold_sum_idle", sum, e_sum);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    step();
    step();
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_sum", sum, 32'h0);
    check("rst_cout", W'(cout), W'(1'b0));
    check("rst_ovf", W'(ovf), W'(1'b0));
    rst_n = 1'b1;
    step();

    do_op(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 0);
    do_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 0);
    do_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 5);
    do_op(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 0);

    // Mid-RUN abort: extra in_valid ignored, reset at idx=2, no result emitted.
    a        = 32'h11111111;
    b        = 32'h22222222;
    cin      = 1'b0;
    in_valid = 1'b1;
    step();  // accept edge, idx=0
    a = 32'h33333333;
    b = 32'h44444444;
    step();  // idx=1, in_valid must be ignored
    in_valid = 1'b0;
    check("abort_busy", W'(busy), W'(1'b1));
    check("abort_in_ready", W'(in_ready), W'(1'b0));
    step();  // idx=2
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_idle_ready", W'(in_ready), W'(1'b1));
    check("abort_idle_busy", W'(busy), W'(1'b0));
    check("abort_sum_cleared", sum, 32'h0);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (out_valid) seen = 1'b1;
        step();
      end
      check("abort_no_result", W'(seen), W'(1'b0));
    end

    do_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b0, 0);

    step();
    step();
    check("scoreboard_drained", W'(exp_q.size()), W'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
